// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants: FSM state encoding and default timing.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam int FREQ    = 125000000;
    localparam int RATE    = 115200;
    localparam int D_WIDTH = 8;
    localparam int N_CYC   = FREQ / RATE;

endpackage
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_fifo
// Description : Synchronous show-ahead FIFO; rd_data is the head whenever !empty.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    // DEPTH is a power of two, so the count MSB alone marks full.
    assign full    = r_count[AW];
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];
    assign w_wr    = wr_en && !full;
    assign w_rd    = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_buffered
// Description : 8N1 LSB-first UART transmitter fed by a byte FIFO (valid/ready).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_buffered #(
    parameter int FREQ       = uart_pkg::FREQ,
    parameter int RATE       = uart_pkg::RATE,
    parameter int D_WIDTH    = uart_pkg::D_WIDTH,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [D_WIDTH-1:0]            s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          send_dout,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    import uart_pkg::*;

    localparam int N_CYC = FREQ / RATE;
    localparam int CNT_W = $clog2(N_CYC);
    localparam int BIT_W = $clog2(D_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(D_WIDTH - 1);

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [D_WIDTH-1:0] r_shift;
    logic               r_dout;

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_cnt_last;
    logic [D_WIDTH-1:0] w_head;

    assign s_ready    = !w_full;
    assign w_push     = s_valid && !w_full;
    assign w_cnt_last = (r_cnt == CNT_LAST);
    assign send_dout  = r_dout;
    assign busy       = (r_state != IDLE);

    uart_byte_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .WIDTH   (D_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_push),
        .wr_data (s_data),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (fifo_count)
    );

    // Pop must fire on exactly the edges where the FSM loads the shift register.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            IDLE:    w_pop = !w_empty;
            STOP:    w_pop = w_cnt_last && !w_empty;
            default: w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_dout    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_shift <= w_head;
                        r_dout  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_cnt_last) begin
                        r_cnt     <= '0;
                        r_bit_cnt <= '0;
                        r_dout    <= r_shift[0];
                        r_state   <= BUSY;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                BUSY: begin
                    if (w_cnt_last) begin
                        r_cnt <= '0;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_dout  <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_dout    <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_cnt_last) begin
                        r_cnt <= '0;
                        // Chain straight into the next start bit when data is waiting.
                        if (!w_empty) begin
                            r_shift <= w_head;
                            r_dout  <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_buffered
// Description : Directed self-checking bench for uart_tx_buffered (N_CYC=10, depth 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffered;

    localparam int FREQ  = 1000000;
    localparam int RATE  = 100000;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic       send_dout;
    logic       busy;
    logic [2:0] fifo_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    uart_tx_buffered #(
        .FREQ       (FREQ),
        .RATE       (RATE),
        .D_WIDTH    (8),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .send_dout  (send_dout),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference receiver: LSB first, samples mid-bit relative to the detected start bit.
    logic       rx_active = 1'b0;
    int         rx_m = 0;
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rx_q[$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_active <= 1'b0;
        end else if (!rx_active) begin
            if (send_dout == 1'b0) begin
                rx_active <= 1'b1;
                rx_m      <= 0;
            end
        end else begin
            rx_m <= rx_m + 1;
            if ((rx_m + 1) >= 15 && (rx_m + 1) <= 85 && ((rx_m + 1) % 10) == 5) begin
                rx_sh <= {send_dout, rx_sh[7:1]};
            end else if ((rx_m + 1) == 95) begin
                if (send_dout) rx_q.push_back(rx_sh);
                rx_active <= 1'b0;
            end
        end
    end

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i < 10)      return 1'b0;
        else if (i < 90) return b[(i - 10) / 10];
        else             return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++; if (send_dout !== 1'b1) begin failures++; $display("FAIL reset_dout got=%b exp=1", send_dout); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", s_ready); end
        repeat (3) tick();
        @(negedge clk) rst = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_single();
        int errs;
        s_data = 8'hA5; s_valid = 1'b1;
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", s_ready); end
        tick();
        s_valid = 1'b0; s_data = 8'h00;
        checks++; if (send_dout !== 1'b1) begin failures++; $display("FAIL single_lat0 got=%b exp=1", send_dout); end
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL single_cnt got=%0d exp=1", fifo_count); end
        tick();
        errs = 0;
        for (int i = 0; i < 100; i++) begin
            checks++;
            if (send_dout !== frame_bit(8'hA5, i) || busy !== 1'b1) begin
                failures++; errs++;
                if (errs < 5) $display("FAIL single_line cyc=%0d got=%b/%b exp=%b/1", i, send_dout, busy, frame_bit(8'hA5, i));
            end
            tick();
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", busy); end
        checks++; if (send_dout !== 1'b1) begin failures++; $display("FAIL single_idle got=%b exp=1", send_dout); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL single_cnt_end got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_back_to_back();
        int  errs;
        logic e;
        s_data = 8'h55; s_valid = 1'b1;
        tick();
        s_data = 8'h0F;
        tick();
        s_valid = 1'b0; s_data = 8'hEE;
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL b2b_cnt got=%0d exp=1", fifo_count); end
        errs = 0;
        for (int i = 0; i < 200; i++) begin
            e = (i < 100) ? frame_bit(8'h55, i) : frame_bit(8'h0F, i - 100);
            checks++;
            if (send_dout !== e || busy !== 1'b1) begin
                failures++; errs++;
                if (errs < 5) $display("FAIL b2b_line cyc=%0d got=%b/%b exp=%b/1", i, send_dout, busy, e);
            end
            tick();
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_full();
        logic [7:0] bytes [6];
        int base, e4, acc, t;
        logic done;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        bytes[3] = 8'h44; bytes[4] = 8'h55; bytes[5] = 8'h66;
        base = rx_q.size();
        for (int j = 0; j < 5; j++) begin
            s_data = bytes[j]; s_valid = 1'b1;
            checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL full_ready%0d got=%b exp=1", j, s_ready); end
            tick();
        end
        e4 = cyc;
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL full_cnt got=%0d exp=4", fifo_count); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", s_ready); end
        s_data = bytes[5];
        done = 1'b0; t = 0;
        while (!done && t < 200) begin
            if (s_ready) done = 1'b1;
            tick();
            t++;
        end
        acc = cyc;
        s_valid = 1'b0; s_data = 8'h00;
        checks++; if (!done || acc !== e4 + 98) begin failures++; $display("FAIL full_accept_edge got=%0d exp=%0d", acc - e4, 98); end
        t = 0;
        while (busy && t < 700) begin tick(); t++; end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_drain_timeout busy=%b exp=0", busy); end
        tick();
        checks++; if (rx_q.size() !== base + 6) begin failures++; $display("FAIL full_rx_count got=%0d exp=%0d", rx_q.size() - base, 6); end
        for (int j = 0; j < 6; j++) begin
            if (rx_q.size() > base + j) begin
                checks++;
                if (rx_q[base + j] !== bytes[j]) begin failures++; $display("FAIL full_order%0d got=%h exp=%h", j, rx_q[base + j], bytes[j]); end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int base, errs;
        base = rx_q.size();
        s_data = 8'h3C; s_valid = 1'b1;
        tick();
        s_data = 8'h99;
        tick();
        s_valid = 1'b0;
        repeat (35) tick();
        checks++; if (busy !== 1'b1 || fifo_count !== 3'd1) begin failures++; $display("FAIL mid_pre got=%b/%0d exp=1/1", busy, fifo_count); end
        #2 rst = 1'b0;
        #1;
        checks++; if (send_dout !== 1'b1) begin failures++; $display("FAIL mid_dout got=%b exp=1", send_dout); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL mid_cnt got=%0d exp=0", fifo_count); end
        @(negedge clk) rst = 1'b1;
        tick();
        errs = 0;
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (send_dout !== 1'b1 || busy !== 1'b0) begin
                failures++; errs++;
                if (errs < 3) $display("FAIL mid_quiet cyc=%0d got=%b/%b exp=1/0", i, send_dout, busy);
            end
            tick();
        end
        s_data = 8'h81; s_valid = 1'b1;
        tick();
        s_valid = 1'b0; s_data = 8'h00;
        tick();
        errs = 0;
        for (int i = 0; i < 100; i++) begin
            checks++;
            if (send_dout !== frame_bit(8'h81, i) || busy !== 1'b1) begin
                failures++; errs++;
                if (errs < 5) $display("FAIL mid_frame cyc=%0d got=%b/%b exp=%b/1", i, send_dout, busy, frame_bit(8'h81, i));
            end
            tick();
        end
        checks++; if (rx_q.size() !== base + 1) begin failures++; $display("FAIL mid_rx_count got=%0d exp=1", rx_q.size() - base); end
        if (rx_q.size() > base) begin
            checks++; if (rx_q[base] !== 8'h81) begin failures++; $display("FAIL mid_rx_byte got=%h exp=81", rx_q[base]); end
        end
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [3];
        int base, t;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h5A;
        base = rx_q.size();
        for (int j = 0; j < 3; j++) begin
            s_data = bytes[j]; s_valid = 1'b1;
            tick();
        end
        s_valid = 1'b0; s_data = 8'h00;
        t = 0;
        while (busy && t < 400) begin tick(); t++; end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL loop_timeout busy=%b exp=0", busy); end
        tick();
        checks++; if (rx_q.size() !== base + 3) begin failures++; $display("FAIL loop_rx_count got=%0d exp=3", rx_q.size() - base); end
        for (int j = 0; j < 3; j++) begin
            if (rx_q.size() > base + j) begin
                checks++;
                if (rx_q[base + j] !== bytes[j]) begin failures++; $display("FAIL loop_byte%0d got=%h exp=%h", j, rx_q[base + j], bytes[j]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        repeat (5) tick();
        test_back_to_back();
        repeat (5) tick();
        test_full();
        repeat (5) tick();
        test_reset_midframe();
        repeat (5) tick();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
